// File: rtl/pe_wht_sched_if.sv
// rtl/pe_wht_sched_if.sv - stream and processing-element bus for pe_wht_sched
// Purpose: bundles the input stream, output stream, external add/sub PE
//          operands/results and the busy/done status of pe_wht_sched.
// Signals: in_valid/in_ready/in_data  input sample stream
//          pe_x/pe_y                  operands to the external PE
//          pe_s/pe_d                  PE results x+y and x-y (mod 2^W)
//          out_valid/out_ready/out_data output sample stream
//          busy                       high while computing or draining
//          done                       pulse on acceptance of the last output
// Modports: slave = the scheduler, master = its environment.
interface pe_wht_sched_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [W-1:0] pe_x;
  logic [W-1:0] pe_y;
  logic [W-1:0] pe_s;
  logic [W-1:0] pe_d;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         busy;
  logic         done;

  modport slave (
    input  in_valid, in_data, pe_s, pe_d, out_ready,
    output in_ready, pe_x, pe_y, out_valid, out_data, busy, done
  );

  modport master (
    output in_valid, in_data, pe_s, pe_d, out_ready,
    input  in_ready, pe_x, pe_y, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/pe_wht_sched.sv
// rtl/pe_wht_sched.sv - 8-point Walsh-Hadamard scheduler around an external add/sub PE
// Purpose: loads 8 samples, runs 3 stages x 4 butterflies through the external
//          PE (one butterfly per cycle, results written back in place), then
//          streams the 8 transformed samples out.
// Ports:   clk    rising-edge clock
//          rst_n  asynchronous active-low reset
//          bus    pe_wht_sched_if.slave (streams, PE operands/results, status)
module pe_wht_sched #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  pe_wht_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [2:0]   ld_idx;
  logic [2:0]   rd_idx;
  logic [3:0]   cnt;      // cnt[3:2] = stage k, cnt[1:0] = butterfly b
  logic [2:0]   bi;
  logic [2:0]   bj;
  logic [W-1:0] mem [8];

  logic in_fire;
  logic out_fire;
  logic last_bfly;

  assign in_fire   = (state == LOAD) && bus.in_valid;
  assign out_fire  = (state == DRAIN) && bus.out_ready;
  assign last_bfly = (cnt == 4'd11);

  // i is b with a zero inserted at bit k; j is its partner with bit k set.
  always_comb begin
    bi = 3'd0;
    case (cnt[3:2])
      2'd0:    bi = {cnt[1:0], 1'b0};
      2'd1:    bi = {cnt[1], 1'b0, cnt[0]};
      default: bi = {1'b0, cnt[1:0]};
    endcase
    bj = bi | (3'd1 << cnt[3:2]);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; COMPUTE never waits on a handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (in_fire && (ld_idx == 3'd7)) state_nxt = COMPUTE;
      COMPUTE: if (last_bfly) state_nxt = DRAIN;
      DRAIN:   if (out_fire && (rd_idx == 3'd7)) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Output logic; everything is gated by state so reset clears all outputs.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.pe_x      = '0;
    bus.pe_y      = '0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (state)
      LOAD: begin
        bus.in_ready = 1'b1;
      end
      COMPUTE: begin
        bus.busy = 1'b1;
        bus.pe_x = mem[bi];
        bus.pe_y = mem[bj];
      end
      DRAIN: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_data  = mem[rd_idx];
        bus.done      = bus.out_ready && (rd_idx == 3'd7);
      end
      default: ;
    endcase
  end

  // Counters; 3-bit indices wrap to 0 naturally after sample 7.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_idx <= 3'd0;
      rd_idx <= 3'd0;
      cnt    <= 4'd0;
    end else begin
      if (in_fire) begin
        ld_idx <= ld_idx + 3'd1;
      end
      if (out_fire) begin
        rd_idx <= rd_idx + 3'd1;
      end
      if (state == COMPUTE) begin
        cnt <= last_bfly ? 4'd0 : cnt + 4'd1;
      end
    end
  end

  // Sample buffer, no reset needed: a frame always fully reloads it.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem[ld_idx] <= bus.in_data;
    end else if (state == COMPUTE) begin
      mem[bi] <= bus.pe_s;
      mem[bj] <= bus.pe_d;
    end
  end

endmodule

// File: tb/tb_pe_wht_sched.sv
// tb/tb_pe_wht_sched.sv - scoreboard bench for pe_wht_sched
module tb_pe_wht_sched;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  pe_wht_sched_if #(.W(W)) ifc ();

  pe_wht_sched #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  // External processing element
  assign ifc.pe_s = ifc.pe_x + ifc.pe_y;
  assign ifc.pe_d = ifc.pe_x - ifc.pe_y;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [7:0] sb [$];
  logic [7:0] fin [8];
  int         out_pos = 0;
  bit         bp_mode = 0;
  bit         stalled = 0;
  int         stall_left = 0;

  // Independent reference: y[k] = sum_n (-1)^popcount(k&n) x[n], mod 256
  task automatic push_expected();
    for (int k = 0; k < 8; k++) begin
      logic [7:0] acc;
      acc = 8'd0;
      for (int n = 0; n < 8; n++) begin
        if ($countones(k & n) % 2 == 1) acc = acc - fin[n];
        else acc = acc + fin[n];
      end
      sb.push_back(acc);
    end
  endtask

  task automatic send_frame();
    for (int s = 0; s < 8; s++) begin
      int n;
      ifc.in_valid = 1'b1;
      ifc.in_data  = fin[s];
      n = 0;
      while (!ifc.in_ready && n < 400) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 400) begin
        chk("in_timeout", 32'd1, 32'd0);
        ifc.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    ifc.in_valid = 1'b0;
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_timeout", sb.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Output monitor: scoreboard pop, hold-while-stalled, done, in_ready.
  initial begin
    bit         held;
    logic [7:0] held_data;
    held = 0;
    held_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 0;
        out_pos = 0;
      end else begin
        if (ifc.out_valid) begin
          chk("in_ready_drain", ifc.in_ready, 1'b0);
          if (held) chk("stall_hold", ifc.out_data, held_data);
          chk("done", ifc.done, ifc.out_ready && (out_pos == 7));
          if (ifc.out_ready) begin
            if (sb.size() == 0) begin
              chk("sb_empty", 32'd1, 32'd0);
            end else begin
              chk("out_data", ifc.out_data, sb.pop_front());
            end
            out_pos = (out_pos + 1) % 8;
            held = 0;
          end else begin
            held = 1;
            held_data = ifc.out_data;
          end
        end else begin
          held = 0;
          if (ifc.done) chk("done_idle", ifc.done, 1'b0);
        end
      end
    end
  end

  // Downstream ready: always high, or random with a forced 5-cycle stall at position 3.
  initial begin
    ifc.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_mode && !stalled && out_pos == 3 && ifc.out_valid) begin
        stall_left = 5;
        stalled = 1;
      end
      if (stall_left > 0) begin
        ifc.out_ready = 1'b0;
        stall_left--;
      end else begin
        ifc.out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  initial begin
    logic [7:0] m [8];
    ifc.in_valid = 1'b0;
    ifc.in_data  = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", ifc.out_valid, 1'b0);
    chk("rst_busy", ifc.busy, 1'b0);
    chk("rst_done", ifc.done, 1'b0);
    chk("rst_pe_x", ifc.pe_x, 8'd0);
    chk("rst_pe_y", ifc.pe_y, 8'd0);
    chk("rst_out_data", ifc.out_data, 8'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", ifc.in_ready, 1'b1);

    // Ramp with PE trace and latency
    for (int s = 0; s < 8; s++) fin[s] = 8'(s + 1);
    sb.push_back(8'h24); sb.push_back(8'hFC); sb.push_back(8'hF8); sb.push_back(8'h00);
    sb.push_back(8'hF0); sb.push_back(8'h00); sb.push_back(8'h00); sb.push_back(8'h00);
    chk("load_pe_x", ifc.pe_x, 8'd0);
    send_frame();
    for (int s = 0; s < 8; s++) m[s] = fin[s];
    for (int c = 0; c < 12; c++) begin
      int k, b, i, j;
      logic [7:0] a0, a1;
      k = c / 4;
      b = c % 4;
      i = ((b >> k) << (k + 1)) | (b & ((1 << k) - 1));
      j = i | (1 << k);
      @(negedge clk);
      chk("cmp_busy", ifc.busy, 1'b1);
      chk("cmp_in_ready", ifc.in_ready, 1'b0);
      chk("cmp_out_valid", ifc.out_valid, 1'b0);
      chk($sformatf("pe_x_c%0d", c), ifc.pe_x, m[i]);
      chk($sformatf("pe_y_c%0d", c), ifc.pe_y, m[j]);
      a0 = m[i];
      a1 = m[j];
      m[i] = a0 + a1;
      m[j] = a0 - a1;
    end
    @(negedge clk);
    chk("latency_out_valid", ifc.out_valid, 1'b1);
    chk("drain_pe_x", ifc.pe_x, 8'd0);
    wait_drained();

    // Impulse, all-ones, overflow: back-to-back, in_valid held during busy
    fin = '{8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    push_expected();
    send_frame();
    fin = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    push_expected();
    send_frame();
    fin = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    push_expected();
    send_frame();
    wait_drained();

    // Random data under backpressure
    bp_mode = 1;
    stalled = 0;
    for (int s = 0; s < 8; s++) fin[s] = 8'($urandom_range(0, 255));
    push_expected();
    send_frame();
    wait_drained();
    bp_mode = 0;
    chk("bp_stalled", stalled, 1'b1);

    // Reset in stage 1 of COMPUTE aborts the frame
    for (int s = 0; s < 8; s++) fin[s] = 8'(8'hA0 + s);
    send_frame();
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("midrst_out_valid", ifc.out_valid, 1'b0);
    chk("midrst_busy", ifc.busy, 1'b0);
    chk("midrst_pe_x", ifc.pe_x, 8'd0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_out_valid_hold", ifc.out_valid, 1'b0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", ifc.in_ready, 1'b1);

    // Fresh ramp after reset
    for (int s = 0; s < 8; s++) fin[s] = 8'(s + 1);
    sb.push_back(8'h24); sb.push_back(8'hFC); sb.push_back(8'hF8); sb.push_back(8'h00);
    sb.push_back(8'hF0); sb.push_back(8'h00); sb.push_back(8'h00); sb.push_back(8'h00);
    send_frame();
    wait_drained();
    chk("final_in_ready", ifc.in_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
